// File: rtl/ecc_decoder_pipe.sv
// ecc_decoder_pipe: two-stage SECDED decoder for 8/16/32-bit extended-Hamming codewords.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module ecc_decoder_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            codeword_width,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_single,
    output logic                  err_double,
    output logic                  err_mode,
    output logic [4:0]            err_syn,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  single_cnt,
    output logic [CNT_WIDTH-1:0]  double_cnt
);

    localparam logic [1:0] MODE_8   = 2'b00;
    localparam logic [1:0] MODE_16  = 2'b01;
    localparam logic [1:0] MODE_32  = 2'b10;

    // Returns {overall parity, syndrome}. Check bits sit at power-of-two
    // positions; XORing the positions of every set bit yields the syndrome.
    function automatic logic [5:0] syndrome(input logic [31:0] cw, input int k, input int p);
        logic [4:0] s;
        logic       ov;
        int         pi;
        int         dj;
        s  = '0;
        ov = 1'b0;
        pi = 0;
        dj = 0;
        for (int pos = 1; pos < 32; pos++) begin
            if (pos < k + p) begin
                if ((pos & (pos - 1)) == 0) begin
                    if (cw[pi[4:0]]) s = s ^ pos[4:0];
                    pi++;
                end else begin
                    if (cw[5'(p + dj)]) s = s ^ pos[4:0];
                    dj++;
                end
            end
        end
        for (int b = 0; b < 32; b++) begin
            if (b < k + p) ov = ov ^ cw[b];
        end
        return {ov, s};
    endfunction

    function automatic logic [25:0] correct(input logic [25:0] d, input logic [4:0] s,
                                            input int k, input int p);
        logic [25:0] r;
        int          dj;
        r  = d;
        dj = 0;
        for (int pos = 3; pos < 32; pos++) begin
            if ((pos < k + p) && ((pos & (pos - 1)) != 0)) begin
                if (pos[4:0] == s) r[dj[4:0]] = ~r[dj[4:0]];
                dj++;
            end
        end
        return r;
    endfunction

    logic                 s1_valid_q;
    logic [1:0]           s1_mode_q;
    logic [25:0]          s1_data_q;
    logic [4:0]           s1_syn_q;
    logic                 s1_ov_q;
    logic [25:0]          s1_data_d;
    logic [4:0]           s1_syn_d;
    logic                 s1_ov_d;

    logic                 s2_valid_q;
    logic [31:0]          s2_data_q;
    logic                 s2_single_q;
    logic                 s2_double_q;
    logic                 s2_mode_q;
    logic [4:0]           s2_syn_q;
    logic [31:0]          s2_data_d;
    logic                 s2_single_d;
    logic                 s2_double_d;
    logic                 s2_mode_d;
    logic [4:0]           s2_syn_d;
    logic [25:0]          corr_data;

    logic [CNT_WIDTH-1:0] single_cnt_q;
    logic [CNT_WIDTH-1:0] double_cnt_q;

    logic                 s2_load;
    logic                 in_accept;
    logic                 out_fire;

    assign s2_load   = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign in_accept = in_valid && in_ready;
    assign out_fire  = s2_valid_q && out_ready;

    always_comb begin
        s1_syn_d  = '0;
        s1_ov_d   = 1'b0;
        s1_data_d = '0;
        case (codeword_width)
            MODE_8: begin
                {s1_ov_d, s1_syn_d} = syndrome(data_in, 4, 4);
                s1_data_d           = {22'b0, data_in[7:4]};
            end
            MODE_16: begin
                {s1_ov_d, s1_syn_d} = syndrome(data_in, 11, 5);
                s1_data_d           = {15'b0, data_in[15:5]};
            end
            MODE_32: begin
                {s1_ov_d, s1_syn_d} = syndrome(data_in, 26, 6);
                s1_data_d           = data_in[31:6];
            end
            default: begin
                s1_syn_d  = '0;
                s1_ov_d   = 1'b0;
                s1_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_ov_q    <= 1'b0;
        end else if (in_accept) begin
            s1_valid_q <= 1'b1;
            s1_mode_q  <= codeword_width;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            s1_ov_q    <= s1_ov_d;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_comb begin
        case (s1_mode_q)
            MODE_8:  corr_data = correct(s1_data_q, s1_syn_q, 4, 4);
            MODE_16: corr_data = correct(s1_data_q, s1_syn_q, 11, 5);
            MODE_32: corr_data = correct(s1_data_q, s1_syn_q, 26, 6);
            default: corr_data = '0;
        endcase
    end

    always_comb begin
        s2_data_d   = '0;
        s2_single_d = 1'b0;
        s2_double_d = 1'b0;
        s2_mode_d   = 1'b0;
        s2_syn_d    = '0;
        if (s1_mode_q == 2'b11) begin
            s2_mode_d = 1'b1;
        end else begin
            s2_syn_d = s1_syn_q;
            // Odd overall parity means exactly one flipped bit is assumed.
            if (s1_ov_q) begin
                s2_single_d = 1'b1;
                s2_data_d   = {6'b0, corr_data};
            end else begin
                s2_data_d   = {6'b0, s1_data_q};
                s2_double_d = (s1_syn_q != 5'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_single_q <= 1'b0;
            s2_double_q <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_syn_q    <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q   <= s2_data_d;
                s2_single_q <= s2_single_d;
                s2_double_q <= s2_double_d;
                s2_mode_q   <= s2_mode_d;
                s2_syn_q    <= s2_syn_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else if (cnt_clr) begin
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else if (out_fire) begin
            if (s2_single_q && (single_cnt_q != '1)) single_cnt_q <= single_cnt_q + 1'b1;
            if (s2_double_q && (double_cnt_q != '1)) double_cnt_q <= double_cnt_q + 1'b1;
        end
    end

    assign out_valid  = s2_valid_q;
    assign data_out   = s2_data_q;
    assign err_single = s2_single_q;
    assign err_double = s2_double_q;
    assign err_mode   = s2_mode_q;
    assign err_syn    = s2_syn_q;
    assign single_cnt = single_cnt_q;
    assign double_cnt = double_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_decoder_pipe.sv
// tb_ecc_decoder_pipe: directed-vector bench for ecc_decoder_pipe.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module tb_ecc_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  codeword_width;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        err_single;
    logic        err_double;
    logic        err_mode;
    logic [4:0]  err_syn;
    logic        cnt_clr;
    logic [15:0] single_cnt;
    logic [15:0] double_cnt;

    int nchk  = 0;
    int nfail = 0;

    logic [1:0]  sm [6];
    logic [31:0] sc [6];
    logic [31:0] sd [6];
    logic        ss [6];
    logic [4:0]  sy [6];
    int          idx;
    int          rcv;
    int          sent;
    int          got;

    ecc_decoder_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .codeword_width (codeword_width),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .err_single     (err_single),
        .err_double     (err_double),
        .err_mode       (err_mode),
        .err_syn        (err_syn),
        .cnt_clr        (cnt_clr),
        .single_cnt     (single_cnt),
        .double_cnt     (double_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One word through an empty pipe: checks 2-cycle latency and the result.
    task automatic run_word(input string tag, input logic [1:0] m, input logic [31:0] cw,
                            input logic [31:0] ed, input logic es, input logic edb,
                            input logic em, input logic [4:0] esyn);
        @(negedge clk);
        codeword_width = m;
        data_in        = cw;
        in_valid       = 1'b1;
        out_ready      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"},  {31'b0, out_valid},  32'd1);
        check({tag, "_data"},   data_out,            ed);
        check({tag, "_single"}, {31'b0, err_single}, {31'b0, es});
        check({tag, "_double"}, {31'b0, err_double}, {31'b0, edb});
        check({tag, "_mode"},   {31'b0, err_mode},   {31'b0, em});
        check({tag, "_syn"},    {27'b0, err_syn},    {27'b0, esyn});
        @(posedge clk); #1;
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        codeword_width = 2'b00;
        data_in        = 32'h0;
        cnt_clr        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_data",  data_out, 32'h0);
        check("rst_errs",  {28'b0, err_single, err_double, err_mode, 1'b0}, 32'h0);
        check("rst_syn",   {27'b0, err_syn}, 32'h0);
        check("rst_scnt",  {16'b0, single_cnt}, 32'h0);
        check("rst_dcnt",  {16'b0, double_cnt}, 32'h0);

        run_word("clean8",   2'b00, 32'h000000B1, 32'hB, 1'b0, 1'b0, 1'b0, 5'd0);
        run_word("upper8",   2'b00, 32'hFFFFFFB1, 32'hB, 1'b0, 1'b0, 1'b0, 5'd0);
        run_word("d1flip8",  2'b00, 32'h00000091, 32'hB, 1'b1, 1'b0, 1'b0, 5'd5);
        check("scnt_1", {16'b0, single_cnt}, 32'd1);
        run_word("ovflip8",  2'b00, 32'h000000B9, 32'hB, 1'b1, 1'b0, 1'b0, 5'd0);
        check("scnt_2", {16'b0, single_cnt}, 32'd2);
        run_word("double8",  2'b00, 32'h00000081, 32'h8, 1'b0, 1'b1, 1'b0, 5'd6);
        check("dcnt_1", {16'b0, double_cnt}, 32'd1);
        run_word("mode11",   2'b11, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("mode11_scnt", {16'b0, single_cnt}, 32'd2);
        check("mode11_dcnt", {16'b0, double_cnt}, 32'd1);
        run_word("clean32",  2'b10, 32'h8000001F, 32'h02000000, 1'b0, 1'b0, 1'b0, 5'd0);
        run_word("p2flip16", 2'b01, 32'h00000037, 32'h1, 1'b1, 1'b0, 1'b0, 5'd4);
        check("scnt_3", {16'b0, single_cnt}, 32'd3);

        sm = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        sc = '{32'h000000B1, 32'h00000033, 32'h00000023, 32'h0000001F, 32'h0000001F, 32'h00000091};
        sd = '{32'hB, 32'h1, 32'h1, 32'h400, 32'h02000000, 32'hB};
        ss = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        sy = '{5'd0, 5'd0, 5'd3, 5'd15, 5'd31, 5'd5};
        idx = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                codeword_width = sm[idx];
                data_in        = sc[idx];
            end
            #1;
            if (cyc >= 4 && cyc < 7) begin
                check("stall_in_ready",  {31'b0, in_ready},  32'd0);
                check("stall_out_valid", {31'b0, out_valid}, 32'd1);
                check("stall_data",      data_out, sd[rcv]);
                check("stall_syn",       {27'b0, err_syn}, {27'b0, sy[rcv]});
            end
            if (out_valid && out_ready) begin
                check("stream_data",   data_out, sd[rcv]);
                check("stream_single", {31'b0, err_single}, {31'b0, ss[rcv]});
                check("stream_syn",    {27'b0, err_syn}, {27'b0, sy[rcv]});
                rcv++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        check("stream_count", rcv, 32'd6);
        @(negedge clk);
        check("stream_drained", {31'b0, out_valid}, 32'd0);
        check("stream_scnt", {16'b0, single_cnt}, 32'd7);
        check("stream_dcnt", {16'b0, double_cnt}, 32'd1);

        // Fill both stages with the output stalled, then reset mid-cycle.
        out_ready      = 1'b0;
        codeword_width = 2'b00;
        data_in        = 32'h000000B1;
        in_valid       = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_in_ready",  {31'b0, in_ready},  32'd0);
        check("full_out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'b0, in_ready},  32'd1);
        check("arst_scnt",      {16'b0, single_cnt}, 32'd0);
        check("arst_dcnt",      {16'b0, double_cnt}, 32'd0);
        check("arst_data",      data_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_word("post_rst", 2'b00, 32'h00000091, 32'hB, 1'b1, 1'b0, 1'b0, 5'd5);
        check("post_rst_scnt", {16'b0, single_cnt}, 32'd1);

        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_scnt", {16'b0, single_cnt}, 32'd0);

        sent           = 0;
        got            = 0;
        codeword_width = 2'b00;
        data_in        = 32'h00000091;
        out_ready      = 1'b1;
        for (int cyc = 0; cyc < 70000 && got < 65537; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 65537);
            #1;
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("sat_count", got, 32'd65537);
        check("sat_scnt",  {16'b0, single_cnt}, 32'h0000FFFF);
        check("sat_dcnt",  {16'b0, double_cnt}, 32'h0);

        // Clear coincides with a single-error output handshake.
        @(negedge clk);
        data_in  = 32'h00000091;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clrhs_valid", {31'b0, out_valid}, 32'd1);
        check("clrhs_single", {31'b0, err_single}, 32'd1);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clrhs_scnt", {16'b0, single_cnt}, 32'd0);
        check("clrhs_drained", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

`default_nettype wire
